// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the oversampling receiver and its companion blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int OS_RATE   = 16;
    localparam int START_MID = 7;

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable baud-tick generator: one-cycle tick every dvsr+1 clocks.
// Shared between the UART receiver and transmitter.
module uart_baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              tick
);

    logic [DVSR_W-1:0] cnt_q;
    logic [DVSR_W-1:0] cnt_d;

    // Using >= lets a divisor that drops below the running count wrap at once
    always_comb begin
        tick  = (cnt_q >= dvsr);
        cnt_d = tick ? '0 : cnt_q + DVSR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with built-in baud generator.
// Pushes each byte with a one-cycle rx_done_tick; frame_err flags a low stop sample.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              rx,
    output logic [DBIT-1:0]   dout,
    output logic              rx_done_tick,
    output logic              frame_err,
    output logic              busy
);

    localparam int SW = 6;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            tick;
    logic            sync1_q;
    logic            sync2_q;
    logic            rx_s;
    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    uart_baud_gen #(
        .DVSR_W (DVSR_W)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .dvsr  (dvsr),
        .tick  (tick)
    );

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    // Mid-start recheck rejects short low glitches
                    if (s_q == SW'(START_MID)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SW'(OS_RATE - 1)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchroniser flops reset high so a reset never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are queued as they are driven and
// checked when rx_done_tick fires.
module tb_uart_rx_os;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int DVSR_W  = 11;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [DVSR_W-1:0] dvsr  = '0;
    logic              rx    = 1'b1;
    logic [DBIT-1:0]   dout;
    logic              rx_done_tick;
    logic              frame_err;
    logic              busy;

    uart_rx_os #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .DVSR_W  (DVSR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dvsr         (dvsr),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   strobe_cnt  = 0;
    int   last_strobe_cyc = 0;
    int   prev_strobe_cyc = 0;
    logic prev_done   = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every strobe must match the oldest queued frame
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            strobe_cnt++;
            prev_strobe_cyc = last_strobe_cyc;
            last_strobe_cyc = cyc;
            vectors++;
            if (prev_done) begin
                miscompares++;
                $display("FAIL strobe_width: rx_done_tick high two cycles in a row, expected one");
            end
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: dout=%02h frame_err=%b, expected no frame", dout, frame_err);
            end else begin
                mon_e = sb_q.pop_front();
                if ({dout, frame_err} !== {mon_e.data, mon_e.ferr}) begin
                    miscompares++;
                    $display("FAIL frame: dout=%02h frame_err=%b, expected dout=%02h frame_err=%b",
                             dout, frame_err, mon_e.data, mon_e.ferr);
                end
                $display("frame %0d: dout=%02h frame_err=%b at cycle %0d", strobe_cnt, dout, frame_err, cyc);
            end
        end else if (frame_err !== 1'b0 && reset === 1'b1) begin
            miscompares++;
            $display("FAIL ferr_alone: frame_err=%b without rx_done_tick, expected 0", frame_err);
        end
        prev_done = (rx_done_tick === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Caller must be at a negedge; leaves the line idle high afterwards
    task automatic drive_frame(input logic [7:0] data, input logic stop_bit, input int bit_clks);
        rx = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (bit_clks) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bit_clks) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_strobe(input int target, input int budget, output bit ok);
        int k = 0;
        while (strobe_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (strobe_cnt >= target);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        idle(3);
        vectors += 4;
        if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %02h, expected 00", dout); end
        if (rx_done_tick !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", rx_done_tick); end
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b, expected 0", frame_err); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        reset = 1'b1;
        idle(5);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int base, t0, lat;
        bit ok;
        dvsr = 0;
        idle(4);
        base = strobe_cnt;
        sb_q.push_back('{data: 8'hA5, ferr: 1'b0});
        t0 = cyc;
        drive_frame(8'hA5, 1'b1, 16);
        wait_strobe(base + 1, 200, ok);
        idle(60);
        lat = last_strobe_cyc - t0;
        vectors += 4;
        if (!ok) begin miscompares++; $display("FAIL basic_timeout: no strobe, expected one"); end
        if (strobe_cnt - base !== 1) begin
            miscompares++; $display("FAIL basic_count: got %0d strobes, expected 1", strobe_cnt - base);
        end
        // 152 ticks from START entry plus synchroniser/IDLE latency
        if (lat < 150 || lat > 157) begin
            miscompares++; $display("FAIL basic_latency: got %0d clk, expected 150..157", lat);
        end
        if (dout !== 8'hA5) begin miscompares++; $display("FAIL basic_hold: dout=%02h, expected A5 held", dout); end
        $display("test_basic: latency %0d clk", lat);
    endtask

    task automatic test_back_to_back();
        int base, gap;
        bit ok;
        dvsr = 3;
        idle(8);
        base = strobe_cnt;
        sb_q.push_back('{data: 8'h00, ferr: 1'b0});
        sb_q.push_back('{data: 8'hFF, ferr: 1'b0});
        drive_frame(8'h00, 1'b1, 64);
        drive_frame(8'hFF, 1'b1, 64);
        wait_strobe(base + 2, 200, ok);
        idle(64);
        gap = last_strobe_cyc - prev_strobe_cyc;
        vectors += 3;
        if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got %0d strobes, expected 2", strobe_cnt - base); end
        if (strobe_cnt - base !== 2) begin
            miscompares++; $display("FAIL b2b_count: got %0d strobes, expected 2", strobe_cnt - base);
        end
        if (gap < 632 || gap > 648) begin
            miscompares++; $display("FAIL b2b_spacing: got %0d clk, expected 632..648", gap);
        end
        $display("test_back_to_back: spacing %0d clk", gap);
    endtask

    task automatic test_glitch();
        int base, busy_cycles;
        dvsr = 0;
        idle(8);
        base = strobe_cnt;
        busy_cycles = 0;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        idle(100);
        vectors += 3;
        if (busy_cycles < 1 || busy_cycles > 12) begin
            miscompares++; $display("FAIL glitch_busy: busy high %0d cycles, expected 1..12", busy_cycles);
        end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: busy=%b, expected 0", busy); end
        if (strobe_cnt !== base) begin
            miscompares++; $display("FAIL glitch_strobe: got %0d strobes, expected 0", strobe_cnt - base);
        end
        $display("test_glitch: busy for %0d cycles", busy_cycles);
    endtask

    task automatic test_frame_err();
        int base;
        bit ok;
        dvsr = 0;
        idle(4);
        base = strobe_cnt;
        sb_q.push_back('{data: 8'h3C, ferr: 1'b1});
        drive_frame(8'h3C, 1'b0, 16);
        idle(64);
        sb_q.push_back('{data: 8'h55, ferr: 1'b0});
        drive_frame(8'h55, 1'b1, 16);
        wait_strobe(base + 2, 200, ok);
        idle(40);
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL ferr_timeout: got %0d strobes, expected 2", strobe_cnt - base); end
        if (strobe_cnt - base !== 2) begin
            miscompares++; $display("FAIL ferr_count: got %0d strobes, expected 2", strobe_cnt - base);
        end
        $display("test_frame_err done");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int base;
        bit ok;
        dvsr = 0;
        idle(4);
        base = strobe_cnt;
        d  = 8'h81;
        rx = 1'b0;
        idle(16);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            idle(16);
        end
        rx = d[4];
        idle(8);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL midframe_busy: got %b, expected 1", busy); end
        #2 reset = 1'b0;
        #1;
        vectors += 4;
        if (dout !== 8'h00) begin miscompares++; $display("FAIL async_dout: got %02h, expected 00", dout); end
        if (rx_done_tick !== 1'b0) begin miscompares++; $display("FAIL async_done: got %b, expected 0", rx_done_tick); end
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL async_ferr: got %b, expected 0", frame_err); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL async_busy: got %b, expected 0", busy); end
        rx = 1'b1;
        idle(10);
        reset = 1'b1;
        idle(20);
        sb_q.push_back('{data: 8'h7E, ferr: 1'b0});
        drive_frame(8'h7E, 1'b1, 16);
        wait_strobe(base + 1, 200, ok);
        idle(40);
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL rst_timeout: no strobe after reset, expected one"); end
        if (strobe_cnt - base !== 1) begin
            miscompares++; $display("FAIL rst_count: got %0d strobes, expected 1", strobe_cnt - base);
        end
        $display("test_reset_midframe done");
    endtask

    task automatic test_dvsr_change();
        int base;
        bit ok;
        reset = 1'b0;
        dvsr  = 11'd650;
        idle(3);
        reset = 1'b1;
        base  = strobe_cnt;
        // Counter now climbs from 0; 600 clocks puts it at 600, well above the new divisor
        idle(600);
        dvsr = 11'd1;
        sb_q.push_back('{data: 8'h96, ferr: 1'b0});
        drive_frame(8'h96, 1'b1, 32);
        wait_strobe(base + 1, 400, ok);
        idle(40);
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL dvsr_timeout: no strobe, expected one"); end
        if (strobe_cnt - base !== 1) begin
            miscompares++; $display("FAIL dvsr_count: got %0d strobes, expected 1", strobe_cnt - base);
        end
        $display("test_dvsr_change done");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_dvsr_change();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d frames outstanding, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
